mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_run_ctrl.sv | 127 ++++++++++++
 tb/tb_mips_run_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/step/halt controller for a MIPS core.
// Gates core writes through core_en and counts retired instructions.
// It also records why the core last stopped.
// Optional feature: define RUNCTRL_BP_EN to build the PC breakpoint comparator.
// Without it, bp_en/bp_addr are ignored and no breakpoint can ever stop the core.
module mips_run_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        clr_cnt,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [15:0] max_cycles,
    output logic        core_en,
    output logic [1:0]  state,
    output logic [1:0]  cause,
    output logic [31:0] retired
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_HALT  = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t     state_q;
    logic       bp_skip;
    logic       bp_hit;
    logic       limit_hit;
    logic       stop;
    logic [1:0] stop_cause;

    assign state = state_q;

`ifdef RUNCTRL_BP_EN
    // Breakpoint hit, suppressed for the first executed instruction after a resume.
    always_comb begin
        bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
    end
`else
    logic unused_bp;

    // Breakpoint logic not built; inputs are deliberately left unused.
    always_comb begin
        bp_hit    = 1'b0;
        unused_bp = ^{bp_en, bp_addr, pc, bp_skip};
    end
`endif

    // Stop condition, its highest-priority cause, and the core write enable.
    always_comb begin
        limit_hit = (max_cycles != 16'd0) && (retired >= CNT_W'(max_cycles));
        stop      = halt_req || bp_hit || limit_hit;

        stop_cause = CAUSE_NONE;
        if (halt_req) begin
            stop_cause = CAUSE_HALT;
        end else if (bp_hit) begin
            stop_cause = CAUSE_BP;
        end else if (limit_hit) begin
            stop_cause = CAUSE_LIMIT;
        end

        core_en = reset && ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stop;
    end

    // State, stop cause, breakpoint skip flag and saturating retired counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cause   <= CAUSE_NONE;
            retired <= '0;
            bp_skip <= 1'b0;
        end else begin
            if (clr_cnt) begin
                retired <= '0;
            end else if (core_en && (retired != {CNT_W{1'b1}})) begin
                retired <= retired + CNT_W'(1);
            end

            if (core_en) begin
                bp_skip <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (!halt_req) begin
                        if (step_req) begin
                            state_q <= ST_STEP;
                            cause   <= CAUSE_NONE;
                            bp_skip <= 1'b1;
                        end else if (run_req) begin
                            state_q <= ST_RUN;
                            cause   <= CAUSE_NONE;
                            bp_skip <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_HALT;
                        cause   <= stop_cause;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_HALT;
                    cause   <= stop_cause;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl.
// The driver applies one directed vector per clock and queues its hand-computed expectation.
// The monitor samples the outputs on the falling edge and checks them against that queue.
module tb_mips_run_ctrl;

    // Control vectors: {reset, run_req, step_req, halt_req, clr_cnt}
    localparam logic [4:0] C_RST  = 5'b00000;
    localparam logic [4:0] C_NONE = 5'b10000;
    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_STEP = 5'b10100;
    localparam logic [4:0] C_HALT = 5'b10010;
    localparam logic [4:0] C_CLR  = 5'b10001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic        clk;
    logic        reset;
    logic        run_req;
    logic        step_req;
    logic        halt_req;
    logic        clr_cnt;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [15:0] max_cycles;
    logic        core_en;
    logic [1:0]  state;
    logic [1:0]  cause;
    logic [31:0] retired;

    // Staged configuration, copied onto the DUT inputs at the start of each vector
    logic [31:0] cfg_pc;
    logic        cfg_bp_en;
    logic [31:0] cfg_bp_addr;
    logic [15:0] cfg_max;

    logic [36:0] exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_fail;
    logic [1:0]  bp_cause;
    logic [31:0] bp_ret;

    mips_run_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .clr_cnt    (clr_cnt),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .max_cycles (max_cycles),
        .core_en    (core_en),
        .state      (state),
        .cause      (cause),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: wait for the rising edge, apply the inputs, and queue the values expected during this cycle
    task automatic cyc(input string nm, input logic [4:0] ctrl, input logic e_en,
                       input logic [1:0] e_st, input logic [1:0] e_cause, input logic [31:0] e_ret);
        @(posedge clk);
        #1;
        {reset, run_req, step_req, halt_req, clr_cnt} = ctrl;
        pc         = cfg_pc;
        bp_en      = cfg_bp_en;
        bp_addr    = cfg_bp_addr;
        max_cycles = cfg_max;
        exp_q.push_back({e_en, e_st, e_cause, e_ret});
        name_q.push_back(nm);
    endtask

    // Monitor: compare the sampled outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [36:0] e;
            logic [36:0] g;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {core_en, state, cause, retired};
            n_cmp = n_cmp + 1;
            if (g !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got en=%0b st=%0d cause=%0d ret=%0d, want en=%0b st=%0d cause=%0d ret=%0d",
                         nm, g[36], g[35:34], g[33:32], g[31:0], e[36], e[35:34], e[33:32], e[31:0]);
            end
        end
    end

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        halt_req    = 1'b0;
        clr_cnt     = 1'b0;
        pc          = '0;
        bp_en       = 1'b0;
        bp_addr     = '0;
        max_cycles  = '0;
        cfg_pc      = '0;
        cfg_bp_en   = 1'b0;
        cfg_bp_addr = 32'h20;
        cfg_max     = '0;

        // Reset and idle
        cyc("reset0", C_RST, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("reset1", C_RST, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("idle0", C_NONE, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("idle1", C_NONE, 1'b0, S_IDLE, 2'd0, 32'd0);

        // Free run, then halt at retired=10
        cyc("run_req", C_RUN, 1'b0, S_IDLE, 2'd0, 32'd0);
        for (int k = 0; k < 10; k++) cyc("run_cnt", C_NONE, 1'b1, S_RUN, 2'd0, 32'(k));
        cyc("halt_cyc", C_HALT, 1'b0, S_RUN, 2'd0, 32'd10);
        cyc("halted", C_NONE, 1'b0, S_HALT, 2'd1, 32'd10);
        cyc("resume", C_RUN, 1'b0, S_HALT, 2'd1, 32'd10);
        cyc("resumed", C_NONE, 1'b1, S_RUN, 2'd0, 32'd10);
        cyc("halt2", C_HALT, 1'b0, S_RUN, 2'd0, 32'd11);

        // Single steps from HALT
        cyc("step1_req", C_STEP, 1'b0, S_HALT, 2'd1, 32'd11);
        cyc("step1", C_NONE, 1'b1, S_STEP, 2'd0, 32'd11);
        cyc("step2_req", C_STEP, 1'b0, S_HALT, 2'd0, 32'd12);
        cyc("step2", C_NONE, 1'b1, S_STEP, 2'd0, 32'd12);
        cyc("step3_req", C_STEP, 1'b0, S_HALT, 2'd0, 32'd13);
        cyc("step3", C_NONE, 1'b1, S_STEP, 2'd0, 32'd13);
        cyc("after_steps", C_NONE, 1'b0, S_HALT, 2'd0, 32'd14);

        // Request priority in HALT: halt_req blocks, step_req beats run_req
        cyc("halt_blocks", 5'b11010, 1'b0, S_HALT, 2'd0, 32'd14);
        cyc("still_halt", C_NONE, 1'b0, S_HALT, 2'd0, 32'd14);
        cyc("step_over_run", 5'b11100, 1'b0, S_HALT, 2'd0, 32'd14);
        cyc("step_won", C_NONE, 1'b1, S_STEP, 2'd0, 32'd14);
        cyc("step_done", C_NONE, 1'b0, S_HALT, 2'd0, 32'd15);

        // Counter clear
        cyc("clr", C_CLR, 1'b0, S_HALT, 2'd0, 32'd15);
        cyc("cleared", C_NONE, 1'b0, S_HALT, 2'd0, 32'd0);

        // Instruction limit of 5
        cfg_max = 16'd5;
        cyc("lim_run", C_RUN, 1'b0, S_HALT, 2'd0, 32'd0);
        for (int k = 0; k < 5; k++) cyc("lim_cnt", C_NONE, 1'b1, S_RUN, 2'd0, 32'(k));
        cyc("lim_stop", C_NONE, 1'b0, S_RUN, 2'd0, 32'd5);
        cyc("lim_halt", C_NONE, 1'b0, S_HALT, 2'd3, 32'd5);
        cyc("lim_step_req", C_STEP, 1'b0, S_HALT, 2'd3, 32'd5);
        cyc("lim_step", C_NONE, 1'b0, S_STEP, 2'd0, 32'd5);
        cyc("lim_step_halt", C_NONE, 1'b0, S_HALT, 2'd3, 32'd5);
        cyc("lim_run2", C_RUN, 1'b0, S_HALT, 2'd3, 32'd5);
        cyc("halt_over_lim", C_HALT, 1'b0, S_RUN, 2'd0, 32'd5);
        cyc("prio_cause", C_NONE, 1'b0, S_HALT, 2'd1, 32'd5);

        // Unlimited run, clear colliding with an executing cycle
        cfg_max = 16'd0;
        cyc("unl_run", C_RUN, 1'b0, S_HALT, 2'd1, 32'd5);
        cyc("unl_cnt", C_NONE, 1'b1, S_RUN, 2'd0, 32'd5);
        cyc("clr_en", C_CLR, 1'b1, S_RUN, 2'd0, 32'd6);
        cyc("clr_wins", C_NONE, 1'b1, S_RUN, 2'd0, 32'd0);
        cyc("post_clr", C_NONE, 1'b1, S_RUN, 2'd0, 32'd1);

        // Breakpoint at 0x20
        cfg_bp_en = 1'b1;
        cfg_pc = 32'h18;
        cyc("bp_pc18", C_NONE, 1'b1, S_RUN, 2'd0, 32'd2);
        cfg_pc = 32'h1C;
        cyc("bp_pc1c", C_NONE, 1'b1, S_RUN, 2'd0, 32'd3);
        cfg_pc = 32'h20;
`ifdef RUNCTRL_BP_EN
        cyc("bp_hit", C_NONE, 1'b0, S_RUN, 2'd0, 32'd4);
        cyc("bp_halt", C_NONE, 1'b0, S_HALT, 2'd2, 32'd4);
        cyc("bp_resume", C_RUN, 1'b0, S_HALT, 2'd2, 32'd4);
        cyc("bp_skip", C_NONE, 1'b1, S_RUN, 2'd0, 32'd4);
        cfg_pc = 32'h24;
        cyc("bp_past", C_NONE, 1'b1, S_RUN, 2'd0, 32'd5);
        cfg_pc = 32'h20;
        cyc("bp_rehit", C_NONE, 1'b0, S_RUN, 2'd0, 32'd6);
        cyc("bp_halt2", C_NONE, 1'b0, S_HALT, 2'd2, 32'd6);
        bp_cause = 2'd2;
        bp_ret   = 32'd6;
`else
        cyc("bp_ignored", C_NONE, 1'b1, S_RUN, 2'd0, 32'd4);
        cfg_pc = 32'h24;
        cyc("bp_ign_past", C_NONE, 1'b1, S_RUN, 2'd0, 32'd5);
        cfg_pc = 32'h20;
        cyc("bp_ign_again", C_NONE, 1'b1, S_RUN, 2'd0, 32'd6);
        cyc("bp_ign_halt", C_HALT, 1'b0, S_RUN, 2'd0, 32'd7);
        cyc("bp_ign_cause", C_NONE, 1'b0, S_HALT, 2'd1, 32'd7);
        bp_cause = 2'd1;
        bp_ret   = 32'd7;
`endif

        // Reset pulsed mid-run with retired=7
        cfg_bp_en = 1'b0;
        cfg_pc = 32'h0;
        cyc("pre_clr", C_CLR, 1'b0, S_HALT, bp_cause, bp_ret);
        cyc("pre_run", C_RUN, 1'b0, S_HALT, bp_cause, 32'd0);
        for (int k = 0; k < 7; k++) cyc("rst_run_cnt", C_NONE, 1'b1, S_RUN, 2'd0, 32'(k));
        cyc("async_rst", C_RST, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("rst_hold", C_RST, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("rst_idle0", C_NONE, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("rst_idle1", C_NONE, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("rst_run_req", C_RUN, 1'b0, S_IDLE, 2'd0, 32'd0);
        cyc("rst_run", C_NONE, 1'b1, S_RUN, 2'd0, 32'd0);
        cyc("rst_halt", C_HALT, 1'b0, S_RUN, 2'd0, 32'd1);
        cyc("rst_halted", C_NONE, 1'b0, S_HALT, 2'd1, 32'd1);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
